btb_port_arbiter: RTL and testbench
===================================

Name: btb_port_arbiter

Overview:
- Owns the single access port of the branch target buffer and shares it between the fetch stage (lookups) and the execute stage (resolved-taken-branch updates).
- Execute-stage updates are buffered in a small FIFO and written into the BTB in cycles not needed by fetch. A starvation limit forces an update slot when fetch holds the port too long.
- Sequences a full BTB invalidation sweep after reset and on pipeline flush.
- Sits between the fetch unit, the execute unit and the BTB.

Parameters:
- SET_COUNT, 4, BTB set count; sweep length.
- ADDR_WIDTH, 64, instruction/target address width.
- UPD_DEPTH, 4, update FIFO depth (power of two, ≥2).
- STARVE_LIMIT, 3, consecutive fetch-granted cycles with a non-empty FIFO before an update slot is forced.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_flush  in  1  pipeline flush; starts invalidation sweep.
- i_fetch_req  in  1  fetch wants a BTB lookup this cycle.
- i_fetch_addr  in  ADDR_WIDTH  fetch PC.
- o_fetch_grant  out  1  lookup performed this cycle; BTB hit/target valid for fetch.
- i_upd_valid  in  1  execute presents a resolved taken branch.
- i_upd_pc  in  ADDR_WIDTH  branch instruction address.
- i_upd_target  in  ADDR_WIDTH  branch target.
- o_upd_ready  out  1  FIFO accepts an update (push = valid & ready).
- o_btb_addr  out  ADDR_WIDTH  address to BTB instr-addr input.
- o_btb_target  out  ADDR_WIDTH  target to BTB target input.
- o_btb_we  out  1  BTB write strobe (drives branch_taken).
- o_btb_inval  out  1  invalidate all ways of set o_btb_inval_idx.
- o_btb_inval_idx  out  $clog2(SET_COUNT)  set being invalidated.
- o_busy  out  1  sweep in progress.

Behaviour:
- FSM states:
  - SWEEP: invalidation sweep.
  - RUN: normal arbitration.
- Reset (i_rst_n=0 at an edge) → SWEEP, idx=0, FIFO empty, starve_cnt=0.
- Output values while in reset:
  - 0: o_fetch_grant, o_upd_ready, o_btb_we, o_btb_inval.
  - o_busy=1.
- SWEEP:
  - Each cycle o_btb_inval=1 and o_btb_inval_idx=idx; idx increments.
  - The cycle with idx=SET_COUNT-1 is the last; next state RUN.
  - Total: exactly SET_COUNT cycles.
  - Outputs held at 0: o_fetch_grant, o_btb_we, o_upd_ready. o_busy=1.
- i_flush=1 in any state:
  - Next state SWEEP, idx=0, FIFO cleared, starve_cnt=0.
  - A flush during SWEEP restarts the sweep from 0.
  - Any push or grant in the flush cycle is discarded; o_upd_ready=0 and o_fetch_grant=0 in that cycle.
- RUN: combinational slot choice each cycle.
  - Update slot when FIFO non-empty AND (!i_fetch_req OR starve_cnt==STARVE_LIMIT):
    - o_btb_we=1, o_btb_addr=head.pc, o_btb_target=head.target.
    - Pop head; starve_cnt←0.
  - Else, lookup slot when i_fetch_req:
    - o_fetch_grant=1, o_btb_addr=i_fetch_addr.
    - If FIFO non-empty, starve_cnt←min(starve_cnt+1, STARVE_LIMIT).
  - Else idle: o_btb_addr=i_fetch_addr, all strobes 0.
  - FIFO empty: starve_cnt←0.
- o_upd_ready = (registered count < UPD_DEPTH) & state==RUN & !i_flush.
  - A pop in the same cycle does not free a slot for that cycle's push.
- Latency: a pushed update is written no earlier than the cycle after the push. There is no same-cycle bypass, even with an empty FIFO.
- Simultaneous push and pop: count unchanged, pointers both advance.
- Pointers wrap modulo UPD_DEPTH; count is $clog2(UPD_DEPTH)+1 bits.
- Updates to the same PC are not merged; FIFO order is preserved.

Decomposition:
- Package btb_ctrl_pkg:
  - state enum (SWEEP, RUN).
  - upd_entry_t struct {pc, target} parameterised via ADDR_WIDTH localparam.
  - Default constants.
- Sub-module btb_upd_fifo: synchronous FIFO with push/pop/count/clear, depth UPD_DEPTH, synchronous active-low reset plus clear input.
- The arbiter top holds the FSM, sweep counter, starvation counter and muxing.

Test Plan:
1. Reset release, SET_COUNT=4 → o_btb_inval high 4 cycles with idx 0,1,2,3; o_busy drops in cycle 5; o_upd_ready=1 in cycle 5.
2. RUN, i_fetch_req=0, push {pc=0x100, target=0x200} → next cycle o_btb_we=1, o_btb_addr=0x100, o_btb_target=0x200; then FIFO empty.
3. i_fetch_req held 1, one update queued, STARVE_LIMIT=3 → grants for 3 cycles, 4th cycle o_btb_we=1, o_fetch_grant=0; grants resume the next cycle.
4. Fetch held, push 4 updates → o_upd_ready=0 after the 4th; a push attempt in a forced-pop cycle is not accepted; entries are written in push order.
5. i_flush asserted with 3 queued updates and sweep index 2 → sweep restarts at idx 0, no o_btb_we for the queued entries, FIFO empty afterwards.
6. i_rst_n low mid-sweep and mid-FIFO → next cycle all outputs at reset values; the sweep runs a full SET_COUNT cycles after release.

Source files
------------

// File: rtl/btb_ctrl_pkg.sv
// Shared types and default constants for the BTB access-port arbiter.
package btb_ctrl_pkg;

  localparam int unsigned DEF_SET_COUNT    = 4;
  localparam int unsigned DEF_ADDR_WIDTH   = 64;
  localparam int unsigned DEF_UPD_DEPTH    = 4;
  localparam int unsigned DEF_STARVE_LIMIT = 3;

  localparam int unsigned PKG_ADDR_WIDTH = DEF_ADDR_WIDTH;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [PKG_ADDR_WIDTH-1:0] pc;
    logic [PKG_ADDR_WIDTH-1:0] target;
  } upd_entry_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO buffering resolved-branch updates; clear empties it in one cycle.
module btb_upd_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/btb_port_arbiter.sv
// Shares the single BTB port between fetch lookups and buffered execute updates,
// and sequences the invalidation sweep after reset and flush.
module btb_port_arbiter
  import btb_ctrl_pkg::*;
#(
  parameter int unsigned SET_COUNT    = DEF_SET_COUNT,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned UPD_DEPTH    = DEF_UPD_DEPTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_fetch_req,
  input  logic [ADDR_WIDTH-1:0]        i_fetch_addr,
  output logic                         o_fetch_grant,
  input  logic                         i_upd_valid,
  input  logic [ADDR_WIDTH-1:0]        i_upd_pc,
  input  logic [ADDR_WIDTH-1:0]        i_upd_target,
  output logic                         o_upd_ready,
  output logic [ADDR_WIDTH-1:0]        o_btb_addr,
  output logic [ADDR_WIDTH-1:0]        o_btb_target,
  output logic                         o_btb_we,
  output logic                         o_btb_inval,
  output logic [$clog2(SET_COUNT)-1:0] o_btb_inval_idx,
  output logic                         o_busy
);

  localparam int unsigned IDX_W = $clog2(SET_COUNT);
  localparam int unsigned CNT_W = $clog2(UPD_DEPTH) + 1;
  localparam int unsigned ST_W  = $clog2(STARVE_LIMIT + 1);

  arb_state_t        state, state_nx;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic [ST_W-1:0]   starve, starve_nx;
  logic [CNT_W-1:0]  count;
  logic [2*ADDR_WIDTH-1:0] head;
  logic              push, pop, fifo_empty, upd_slot;

  btb_upd_fifo #(
    .WIDTH (2 * ADDR_WIDTH),
    .DEPTH (UPD_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clear (i_flush),
    .push  (push),
    .pop   (pop),
    .wdata ({i_upd_pc, i_upd_target}),
    .rdata (head),
    .count (count)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= SWEEP;
      idx    <= '0;
      starve <= '0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      starve <= starve_nx;
    end
  end

  assign fifo_empty = (count == '0);
  assign upd_slot   = !fifo_empty && (!i_fetch_req || starve == ST_W'(STARVE_LIMIT));

  always_comb begin
    state_nx        = state;
    idx_nx          = idx;
    starve_nx       = starve;
    o_fetch_grant   = 1'b0;
    o_upd_ready     = 1'b0;
    o_btb_we        = 1'b0;
    o_btb_inval     = 1'b0;
    o_btb_inval_idx = idx;
    o_busy          = 1'b0;
    o_btb_addr      = i_fetch_addr;
    o_btb_target    = head[ADDR_WIDTH-1:0];
    push            = 1'b0;
    pop             = 1'b0;

    if (!i_rst_n) begin
      o_busy = 1'b1;
    end else begin
      case (state)
        SWEEP: begin
          o_btb_inval = 1'b1;
          o_busy      = 1'b1;
          idx_nx      = idx + IDX_W'(1);
          if (idx == IDX_W'(SET_COUNT - 1)) begin
            state_nx = RUN;
            idx_nx   = '0;
          end
        end
        default: begin
          // Readiness uses the registered count, so a pop never frees a slot for a same-cycle push.
          o_upd_ready = (count < CNT_W'(UPD_DEPTH));
          push        = i_upd_valid && o_upd_ready;
          if (upd_slot) begin
            o_btb_we   = 1'b1;
            o_btb_addr = head[2*ADDR_WIDTH-1:ADDR_WIDTH];
            pop        = 1'b1;
            starve_nx  = '0;
          end else if (i_fetch_req) begin
            o_fetch_grant = 1'b1;
            if (starve != ST_W'(STARVE_LIMIT)) starve_nx = starve + ST_W'(1);
          end
          if (fifo_empty) starve_nx = '0;
        end
      endcase

      if (i_flush) begin
        o_fetch_grant = 1'b0;
        o_upd_ready   = 1'b0;
        o_btb_we      = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        state_nx      = SWEEP;
        idx_nx        = '0;
        starve_nx     = '0;
      end
    end
  end

endmodule

// File: tb/tb_btb_port_arbiter.sv
// Randomized bench for btb_port_arbiter against a queue-based reference model.
module tb_btb_port_arbiter;
  import btb_ctrl_pkg::*;

  localparam int unsigned SET_COUNT    = 4;
  localparam int unsigned ADDR_WIDTH   = 64;
  localparam int unsigned UPD_DEPTH    = 4;
  localparam int unsigned STARVE_LIMIT = 3;

  logic                  clk;
  logic                  rst_n;
  logic                  flush;
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_grant;
  logic                  upd_valid;
  logic [ADDR_WIDTH-1:0] upd_pc;
  logic [ADDR_WIDTH-1:0] upd_target;
  logic                  upd_ready;
  logic [ADDR_WIDTH-1:0] btb_addr;
  logic [ADDR_WIDTH-1:0] btb_target;
  logic                  btb_we;
  logic                  btb_inval;
  logic [$clog2(SET_COUNT)-1:0] btb_inval_idx;
  logic                  busy;

  btb_port_arbiter #(
    .SET_COUNT    (SET_COUNT),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .UPD_DEPTH    (UPD_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_flush         (flush),
    .i_fetch_req     (fetch_req),
    .i_fetch_addr    (fetch_addr),
    .o_fetch_grant   (fetch_grant),
    .i_upd_valid     (upd_valid),
    .i_upd_pc        (upd_pc),
    .i_upd_target    (upd_target),
    .o_upd_ready     (upd_ready),
    .o_btb_addr      (btb_addr),
    .o_btb_target    (btb_target),
    .o_btb_we        (btb_we),
    .o_btb_inval     (btb_inval),
    .o_btb_inval_idx (btb_inval_idx),
    .o_busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         sweep_left;
  int         starve;
  upd_entry_t q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom(), $urandom()};
  endfunction

  // One clock cycle: drive at negedge, compare just after, advance the model.
  task automatic cyc(input bit r, input bit fl, input bit fr, input logic [63:0] fa,
                     input bit uv, input logic [63:0] upc, input logic [63:0] utg,
                     input bit do_check);
    bit         e_grant, e_ready, e_we, e_inval, e_busy, e_upd, chk_addr;
    int         e_idx;
    logic [63:0] e_addr, e_tgt;
    bit         pre_empty;
    upd_entry_t ent;

    @(negedge clk);
    rst_n = r; flush = fl; fetch_req = fr; fetch_addr = fa;
    upd_valid = uv; upd_pc = upc; upd_target = utg;
    #1;

    e_grant = 0; e_ready = 0; e_we = 0; e_inval = 0; e_busy = 1; e_upd = 0;
    chk_addr = 0; e_idx = 0; e_addr = fa; e_tgt = '0;
    if (r) begin
      if (sweep_left > 0) begin
        e_inval = 1;
        e_idx   = SET_COUNT - sweep_left;
      end else begin
        e_busy = 0;
        if (!fl) begin
          chk_addr = 1;
          e_ready  = (q.size() < UPD_DEPTH);
          e_upd    = (q.size() > 0) && (!fr || starve == STARVE_LIMIT);
          e_grant  = !e_upd && fr;
          e_we     = e_upd;
          if (e_upd) begin
            e_addr = q[0].pc;
            e_tgt  = q[0].target;
          end
        end
      end
    end

    if (do_check) begin
      check_val("grant", fetch_grant, e_grant);
      check_val("ready", upd_ready, e_ready);
      check_val("we", btb_we, e_we);
      check_val("inval", btb_inval, e_inval);
      check_val("busy", busy, e_busy);
      if (e_inval)  check_val("inval_idx", btb_inval_idx, e_idx);
      if (chk_addr) check_val("btb_addr", btb_addr, e_addr);
      if (e_we)     check_val("btb_target", btb_target, e_tgt);
    end

    if (!r || fl) begin
      sweep_left = SET_COUNT;
      q.delete();
      starve = 0;
    end else if (sweep_left > 0) begin
      sweep_left--;
    end else begin
      pre_empty = (q.size() == 0);
      if (e_upd) void'(q.pop_front());
      if (uv && e_ready) begin
        ent.pc = upc; ent.target = utg;
        q.push_back(ent);
      end
      if (pre_empty || e_upd) starve = 0;
      else if (fr && starve < STARVE_LIMIT) starve++;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, r64(), 0, '0, '0, 1);
  endtask

  initial begin
    int bias;
    rst_n = 0; flush = 0; fetch_req = 0; fetch_addr = '0;
    upd_valid = 0; upd_pc = '0; upd_target = '0;
    sweep_left = SET_COUNT; starve = 0;

    cyc(0, 0, 0, '0, 0, '0, '0, 0);
    cyc(0, 0, 0, '0, 1, 64'h1, 64'h2, 1);
    idle(6);

    // single update with fetch idle
    cyc(1, 0, 0, 64'h40, 1, 64'h100, 64'h200, 1);
    idle(2);

    // starvation: one queued entry, fetch held
    cyc(1, 0, 1, 64'h80, 1, 64'h300, 64'h400, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 1, r64(), 0, '0, '0, 1);

    // fill the FIFO while fetch holds the port, keep pushing
    for (int i = 0; i < 12; i++) cyc(1, 0, 1, r64(), 1, 64'h1000 + i, 64'h2000 + i, 1);
    idle(6);

    // flush with queued entries, then flush again at sweep index 2
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, r64(), 1, r64(), r64(), 1);
    cyc(1, 1, 1, r64(), 1, r64(), r64(), 1);
    cyc(1, 0, 0, r64(), 0, '0, '0, 1);
    cyc(1, 0, 0, r64(), 0, '0, '0, 1);
    cyc(1, 1, 0, r64(), 1, r64(), r64(), 1);
    idle(6);

    // reset mid-FIFO and mid-sweep
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, r64(), 1, r64(), r64(), 1);
    cyc(0, 0, 1, r64(), 1, r64(), r64(), 1);
    cyc(1, 0, 1, r64(), 1, r64(), r64(), 1);
    cyc(0, 0, 0, r64(), 0, '0, '0, 1);
    idle(7);

    for (int i = 0; i < 4000; i++) begin
      case ((i / 200) % 4)
        0: bias = 10;
        1: bias = 50;
        2: bias = 90;
        default: bias = 100;
      endcase
      cyc($urandom_range(0, 299) != 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 99) < bias, r64(), $urandom_range(0, 1) == 1,
          r64(), r64(), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
